// File: rtl/dec_pkg.sv
// Shared types and helpers for the dec_nx2n_scan decoder family.
// DEC_ONEHOT_CHK_EN (optional) enables the one-hot checker in the top.
package dec_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Reference one-hot used by the checker; covers decoders up to 64 lines.
  localparam int unsigned ONEHOT_W = 64;

  function automatic logic [ONEHOT_W-1:0] onehot(input int unsigned idx);
    return ONEHOT_W'(1) << idx;
  endfunction

endpackage

// File: rtl/dec_core.sv
// Combinational N-to-2^N one-hot decoder built recursively from mux_2x1 cells:
// the MSB steers the (N-1)-bit sub-decode into the lower or upper half.
module dec_core #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]    sel,
  output logic [2**N-1:0] dec_c
);

  generate
    if (N == 1) begin : g_leaf
      mux_2x1 u_lo (.a(1'b1), .b(1'b0), .sel(sel[0]), .y_c(dec_c[0]));
      mux_2x1 u_hi (.a(1'b0), .b(1'b1), .sel(sel[0]), .y_c(dec_c[1]));
    end else begin : g_node
      localparam int unsigned H = 2**(N-1);
      logic [H-1:0] low_c;

      dec_core #(.N(N-1)) u_sub (
        .sel  (sel[N-2:0]),
        .dec_c(low_c)
      );

      for (genvar j = 0; j < H; j++) begin : g_split
        mux_2x1 u_lo (.a(low_c[j]), .b(1'b0),     .sel(sel[N-1]), .y_c(dec_c[j]));
        mux_2x1 u_hi (.a(1'b0),     .b(low_c[j]), .sel(sel[N-1]), .y_c(dec_c[j+H]));
      end
    end
  endgenerate

endmodule

// File: rtl/mux_2x1.sv
// Single-bit 2:1 multiplexer, the leaf cell of the recursive decoder.
module mux_2x1 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y_c
);

  assign y_c = sel ? b : a;

endmodule

// File: rtl/dec_nx2n_scan.sv
// Registered N-to-2^N one-hot decoder with DIRECT and SCAN modes.
// Define DEC_ONEHOT_CHK_EN to add the sticky err output (checker valid for N <= 6).
module dec_nx2n_scan
  import dec_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned DWELL = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            mode,
  input  logic [N-1:0]    i,
  input  logic            i_valid,
  output logic [2**N-1:0] y,
  output logic            y_valid,
  output logic [N-1:0]    scan_idx,
  output logic            wrap
`ifdef DEC_ONEHOT_CHK_EN
  ,
  output logic            err
`endif
);

  localparam int unsigned W  = 2**N;
  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic [W-1:0]    y_nxt;
  logic            y_valid_nxt;
  logic [N-1:0]    idx_nxt;
  logic            wrap_nxt;
  logic [N-1:0]    sel_c;
  logic [W-1:0]    dec_c;

  // Index fed to the decoder: next scan line, direct select, or line 0 on scan entry.
  always_comb begin
    sel_c = '0;
    case (state)
      SCAN:    sel_c = scan_idx + N'(1);
      DIRECT:  sel_c = i;
      default: sel_c = '0;
    endcase
  end

  dec_core #(.N(N)) u_dec (
    .sel  (sel_c),
    .dec_c(dec_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: every mode change passes through one IDLE cycle.
  always_comb begin
    state_nxt = state;
    if (en) begin
      case (state)
        IDLE:    state_nxt = (mode == MODE_SCAN) ? SCAN : DIRECT;
        DIRECT:  if (mode == MODE_SCAN)   state_nxt = IDLE;
        SCAN:    if (mode == MODE_DIRECT) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs and dwell counter.
  always_comb begin
    y_nxt       = y;
    y_valid_nxt = y_valid;
    idx_nxt     = scan_idx;
    cnt_nxt     = cnt;
    wrap_nxt    = 1'b0;
    if (en) begin
      case (state)
        IDLE: begin
          y_nxt       = (mode == MODE_SCAN) ? dec_c : '0;
          y_valid_nxt = (mode == MODE_SCAN);
          idx_nxt     = '0;
          cnt_nxt     = '0;
        end
        DIRECT: begin
          if (mode == MODE_SCAN) begin
            y_nxt       = '0;
            y_valid_nxt = 1'b0;
            idx_nxt     = '0;
            cnt_nxt     = '0;
          end else if (i_valid) begin
            y_nxt       = dec_c;
            y_valid_nxt = 1'b1;
            idx_nxt     = i;
          end
        end
        SCAN: begin
          if (mode == MODE_DIRECT) begin
            y_nxt       = '0;
            y_valid_nxt = 1'b0;
            idx_nxt     = '0;
            cnt_nxt     = '0;
          end else if (cnt == CNT_LAST) begin
            cnt_nxt  = '0;
            idx_nxt  = sel_c;
            y_nxt    = dec_c;
            wrap_nxt = &scan_idx;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: begin
          y_nxt       = '0;
          y_valid_nxt = 1'b0;
          idx_nxt     = '0;
          cnt_nxt     = '0;
        end
      endcase
    end
  end

  // Output and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      y        <= '0;
      y_valid  <= 1'b0;
      scan_idx <= '0;
      cnt      <= '0;
      wrap     <= 1'b0;
    end else begin
      y        <= y_nxt;
      y_valid  <= y_valid_nxt;
      scan_idx <= idx_nxt;
      cnt      <= cnt_nxt;
      wrap     <= wrap_nxt;
    end
  end

`ifdef DEC_ONEHOT_CHK_EN
  logic onehot_ok_c;
  logic match_c;

  assign onehot_ok_c = (y != '0) && ((y & (y - W'(1))) == '0);
  assign match_c     = (y == W'(onehot(32'(scan_idx))));

  // Sticky flag: a valid output must be the one-hot of scan_idx.
  always_ff @(posedge clk) begin
    if (rst)                                         err <= 1'b0;
    else if (y_valid && !(onehot_ok_c && match_c))   err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_dec_nx2n_scan.sv
// Scoreboard bench for dec_nx2n_scan: two instances (DWELL=3 and DWELL=1) share stimulus
// and are compared every cycle against a tick-count reference model.
module tb_dec_nx2n_scan;

  typedef struct packed {
    logic [3:0] y;
    logic       v;
    logic [1:0] idx;
    logic       wrap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic [1:0] i = '0;
  logic       i_valid = 1'b0;

  logic [3:0] y3, y1;
  logic       v3, v1;
  logic [1:0] idx3, idx1;
  logic       wrap3, wrap1;
`ifdef DEC_ONEHOT_CHK_EN
  logic       err3, err1;
`endif

  int checks = 0;
  int errors = 0;

  exp_t q3[$];
  exp_t q1[$];
  exp_t mon3, mon1;

  // Reference model state: 0 idle, 1 direct, 2 scan; scan position kept as elapsed ticks.
  int         m_st[2];
  int         m_t[2];
  logic [3:0] m_y[2];
  logic       m_v[2];
  logic [1:0] m_idx[2];
  logic       m_wrap[2];
  int         dw[2];

  always #5 clk = ~clk;

  dec_nx2n_scan #(.N(2), .DWELL(3)) dut3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .i(i), .i_valid(i_valid),
    .y(y3), .y_valid(v3), .scan_idx(idx3), .wrap(wrap3)
`ifdef DEC_ONEHOT_CHK_EN
    , .err(err3)
`endif
  );

  dec_nx2n_scan #(.N(2), .DWELL(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .i(i), .i_valid(i_valid),
    .y(y1), .y_valid(v1), .scan_idx(idx1), .wrap(wrap1)
`ifdef DEC_ONEHOT_CHK_EN
    , .err(err1)
`endif
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input int k, input logic r, input logic e, input logic m,
                            input logic [1:0] ii, input logic iv);
    if (r) begin
      m_st[k] = 0; m_t[k] = 0; m_y[k] = '0; m_v[k] = 1'b0; m_idx[k] = '0; m_wrap[k] = 1'b0;
    end else if (!e) begin
      m_wrap[k] = 1'b0;
    end else begin
      m_wrap[k] = 1'b0;
      case (m_st[k])
        0: begin
          m_st[k]  = m ? 2 : 1;
          m_t[k]   = 0;
          m_idx[k] = '0;
          m_y[k]   = m ? 4'b0001 : 4'b0000;
          m_v[k]   = m;
        end
        1: begin
          if (m) begin
            m_st[k] = 0; m_y[k] = '0; m_v[k] = 1'b0; m_idx[k] = '0;
          end else if (iv) begin
            m_y[k] = 4'b0001 << ii; m_idx[k] = ii; m_v[k] = 1'b1;
          end
        end
        default: begin
          if (!m) begin
            m_st[k] = 0; m_y[k] = '0; m_v[k] = 1'b0; m_idx[k] = '0;
          end else begin
            m_t[k]++;
            m_idx[k]  = 2'((m_t[k] / dw[k]) % 4);
            m_y[k]    = 4'b0001 << m_idx[k];
            m_wrap[k] = ((m_t[k] % (4 * dw[k])) == 0);
          end
        end
      endcase
    end
  endtask

  // Drive one clock of inputs, then record what both instances must show after the edge.
  task automatic drive(input logic r, input logic e, input logic m,
                       input logic [1:0] ii, input logic iv);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; mode = m; i = ii; i_valid = iv;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      model_step(k, r, e, m, ii, iv);
      x.y = m_y[k]; x.v = m_v[k]; x.idx = m_idx[k]; x.wrap = m_wrap[k];
      if (k == 0) q3.push_back(x);
      else        q1.push_back(x);
    end
  endtask

  // Monitor: outputs are registered, so every cycle presents a result to check.
  always @(negedge clk) begin
    if (q3.size() > 0) begin
      mon3 = q3.pop_front();
      chk("d3_y",        8'(y3),    8'(mon3.y));
      chk("d3_y_valid",  8'(v3),    8'(mon3.v));
      chk("d3_scan_idx", 8'(idx3),  8'(mon3.idx));
      chk("d3_wrap",     8'(wrap3), 8'(mon3.wrap));
`ifdef DEC_ONEHOT_CHK_EN
      chk("d3_err",      8'(err3),  8'd0);
`endif
    end
    if (q1.size() > 0) begin
      mon1 = q1.pop_front();
      chk("d1_y",        8'(y1),    8'(mon1.y));
      chk("d1_y_valid",  8'(v1),    8'(mon1.v));
      chk("d1_scan_idx", 8'(idx1),  8'(mon1.idx));
      chk("d1_wrap",     8'(wrap1), 8'(mon1.wrap));
`ifdef DEC_ONEHOT_CHK_EN
      chk("d1_err",      8'(err1),  8'd0);
`endif
    end
  end

  initial begin
    logic cur_mode;
    dw[0] = 3; dw[1] = 1;
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_t[k] = 0; m_y[k] = '0; m_v[k] = 1'b0; m_idx[k] = '0; m_wrap[k] = 1'b0;
    end

    // Reset, then DIRECT decode and hold.
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 2, 1);
    for (int c = 0; c < 3; c++) drive(0, 1, 0, 3, 0);
    drive(0, 1, 0, 1, 1);
    drive(0, 0, 0, 3, 1);
    drive(0, 1, 0, 0, 1);

    // SCAN: two laps and change.
    for (int c = 0; c < 30; c++) drive(0, 1, 1, 2'($urandom), 1'($urandom));

    // Freeze while line 1 is asserted, then resume.
    for (int c = 0; c < 40 && m_y[0] != 4'b0010; c++) drive(0, 1, 1, 0, 0);
    for (int c = 0; c < 5; c++) drive(0, 0, 1, 0, 0);
    for (int c = 0; c < 8; c++) drive(0, 1, 1, 0, 0);

    // Mode change to DIRECT mid-scan, wait, then decode.
    drive(0, 1, 0, 0, 0);
    for (int c = 0; c < 4; c++) drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 3, 1);

    // Reset mid-scan.
    for (int c = 0; c < 7; c++) drive(0, 1, 1, 0, 0);
    drive(1, 1, 1, 0, 0);
    drive(1, 1, 1, 0, 0);
    drive(0, 0, 1, 0, 0);

    // Randomised traffic with occasional mode flips, stalls and resets.
    cur_mode = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(19) == 0) cur_mode = ~cur_mode;
      drive(($urandom_range(149) == 0), ($urandom_range(9) != 0), cur_mode,
            2'($urandom), 1'($urandom));
    end

    @(negedge clk);
    #1;
    chk("sb_drain_d3", 8'(q3.size()), 8'd0);
    chk("sb_drain_d1", 8'(q1.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
